// File: rtl/rvv_pkg.sv
// Shared RVV configuration constants: default VLEN, legal SEW/LMUL encodings
// and a log2 helper for the power-of-two encodings.
package rvv_pkg;

  localparam int unsigned VLEN_DEFAULT = 128;

  // Legal element widths, in bits
  localparam logic [7:0] SEW_8   = 8'd8;
  localparam logic [7:0] SEW_16  = 8'd16;
  localparam logic [7:0] SEW_32  = 8'd32;
  localparam logic [7:0] SEW_64  = 8'd64;
  localparam logic [7:0] SEW_128 = 8'd128;

  // Legal register-group multipliers, as integer values
  localparam logic [4:0] LMUL_1  = 5'd1;
  localparam logic [4:0] LMUL_2  = 5'd2;
  localparam logic [4:0] LMUL_4  = 5'd4;
  localparam logic [4:0] LMUL_8  = 5'd8;
  localparam logic [4:0] LMUL_16 = 5'd16;

  // log2 of a one-hot value; the result is only meaningful for a power of two
  function automatic logic [2:0] log2_pow2(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/vlmax_calc.sv
// Combinational SEW/LMUL decoder: flags legal pairs and computes
// VLMAX = (VLEN << log2(lmul)) >> log2(sew) using shifts only.
// Ports:
//   sew      requested element width in bits
//   lmul     requested register-group multiplier (integer value)
//   legal_c  1 when both sew and lmul are legal encodings
//   vlmax_c  VLMAX for a legal pair, 0 otherwise
module vlmax_calc
  import rvv_pkg::*;
#(
  parameter int unsigned VLEN    = VLEN_DEFAULT,
  parameter int unsigned VLMAX_W = 32'($clog2(VLEN)) + 5
) (
  input  logic [7:0]         sew,
  input  logic [4:0]         lmul,
  output logic               legal_c,
  output logic [VLMAX_W-1:0] vlmax_c
);

  logic sew_ok;
  logic lmul_ok;

  // Decode legality and scale VLEN by the group and element-width ratio
  always_comb begin
    sew_ok  = 1'b0;
    lmul_ok = 1'b0;
    vlmax_c = '0;

    case (sew)
      SEW_8, SEW_16, SEW_32, SEW_64, SEW_128: sew_ok = 1'b1;
      default:                                sew_ok = 1'b0;
    endcase

    case (lmul)
      LMUL_1, LMUL_2, LMUL_4, LMUL_8, LMUL_16: lmul_ok = 1'b1;
      default:                                 lmul_ok = 1'b0;
    endcase

    legal_c = sew_ok & lmul_ok;

    if (legal_c) begin
      vlmax_c = (VLMAX_W'(VLEN) << log2_pow2(8'(lmul))) >> log2_pow2(sew);
    end
  end

endmodule

// File: rtl/vl_setup.sv
// vsetvl-style vector-length configuration unit. Every cycle is a request;
// results are registered with one cycle of latency.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   SEW         requested element width in bits
//   lmul        requested register-group multiplier (integer value)
//   AVL         application vector length
//   valid       registered: SEW/lmul pair was legal
//   vl          registered granted vector length, min(AVL, VLMAX)
//   new_AVL     registered AVL - vl (AVL passed through when illegal)
module vl_setup
  import rvv_pkg::*;
#(
  parameter int unsigned VLEN  = VLEN_DEFAULT,
  parameter int unsigned AVL_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       SEW,
  input  logic [4:0]       lmul,
  input  logic [AVL_W-1:0] AVL,
  output logic             valid,
  output logic [AVL_W-1:0] vl,
  output logic [AVL_W-1:0] new_AVL
);

  localparam int unsigned VLMAX_W = 32'($clog2(VLEN)) + 5;
  // Comparison width wide enough for both AVL and VLMAX
  localparam int unsigned CMP_W   = (AVL_W > VLMAX_W) ? AVL_W : VLMAX_W;

  logic               legal;
  logic [VLMAX_W-1:0] vlmax;

  logic               valid_d,   valid_q;
  logic [AVL_W-1:0]   vl_d,      vl_q;
  logic [AVL_W-1:0]   new_avl_d, new_avl_q;

  vlmax_calc #(
    .VLEN    (VLEN),
    .VLMAX_W (VLMAX_W)
  ) u_vlmax_calc (
    .sew     (SEW),
    .lmul    (lmul),
    .legal_c (legal),
    .vlmax_c (vlmax)
  );

  // Grant min(AVL, VLMAX); when VLMAX is chosen it is <= AVL, so it fits AVL_W
  always_comb begin
    valid_d   = 1'b0;
    vl_d      = '0;
    new_avl_d = AVL;

    if (legal) begin
      valid_d = 1'b1;
      if (CMP_W'(AVL) < CMP_W'(vlmax)) begin
        vl_d = AVL;
      end else begin
        vl_d = AVL_W'(vlmax);
      end
      new_avl_d = AVL - vl_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      vl_q      <= '0;
      new_avl_q <= '0;
    end else begin
      valid_q   <= valid_d;
      vl_q      <= vl_d;
      new_avl_q <= new_avl_d;
    end
  end

  assign valid   = valid_q;
  assign vl      = vl_q;
  assign new_AVL = new_avl_q;

endmodule

// File: tb/tb_vl_setup.sv
// Self-checking bench for vl_setup: directed cases plus randomized requests
// checked against an arithmetic reference model.
module tb_vl_setup;

  localparam int unsigned VLEN  = 128;
  localparam int unsigned AVL_W = 9;

  logic             clk;
  logic             rst_n;
  logic [7:0]       SEW;
  logic [4:0]       lmul;
  logic [AVL_W-1:0] AVL;
  logic             valid;
  logic [AVL_W-1:0] vl;
  logic [AVL_W-1:0] new_AVL;

  int checks = 0;
  int errors = 0;

  vl_setup #(
    .VLEN  (VLEN),
    .AVL_W (AVL_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SEW     (SEW),
    .lmul    (lmul),
    .AVL     (AVL),
    .valid   (valid),
    .vl      (vl),
    .new_AVL (new_AVL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed response: valid in bit 18, vl in 17:9, new_AVL in 8:0
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%0d vl=%0d new_AVL=%0d, expected valid=%0d vl=%0d new_AVL=%0d",
               tag, got[18], got[17:9], got[8:0], exp[18], exp[17:9], exp[8:0]);
    end
  endtask

  function automatic logic [31:0] observed();
    return 32'({valid, vl, new_AVL});
  endfunction

  // Reference: VLMAX = VLEN*lmul/SEW, vl = min(AVL, VLMAX)
  function automatic logic [31:0] ref_resp(input int unsigned s, input int unsigned l,
                                           input int unsigned a);
    bit          ok;
    int unsigned vmax;
    int unsigned v;
    ok = (s == 8 || s == 16 || s == 32 || s == 64 || s == 128) &&
         (l == 1 || l == 2 || l == 4 || l == 8 || l == 16);
    if (!ok) return a;
    vmax = VLEN * l / s;
    v    = (a < vmax) ? a : vmax;
    return 32'h4_0000 | (v << 9) | (a - v);
  endfunction

  // Called at a negedge: drive, scramble inputs after the edge, check at next negedge
  task automatic apply(input string tag, input logic [7:0] s, input logic [4:0] l,
                       input logic [AVL_W-1:0] a);
    SEW  = s;
    lmul = l;
    AVL  = a;
    @(posedge clk);
    #1;
    SEW  = 8'($urandom);
    lmul = 5'($urandom);
    AVL  = AVL_W'($urandom);
    @(negedge clk);
    check_eq(tag, observed(), ref_resp(32'(s), 32'(l), 32'(a)));
  endtask

  initial begin
    logic [7:0]       rs;
    logic [4:0]       rl;
    logic [AVL_W-1:0] ra;
    logic [7:0]       sew_tab [5];
    logic [4:0]       lmul_tab[5];
    sew_tab  = '{8'd8, 8'd16, 8'd32, 8'd64, 8'd128};
    lmul_tab = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

    rst_n = 1'b0;
    SEW   = '0;
    lmul  = '0;
    AVL   = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", observed(), 32'd0);
    rst_n = 1'b1;

    apply("zero_encodings", 8'd0, 5'd0, 9'd0);
    check_eq("zero_encodings_const", observed(), 32'd0);

    apply("sew64_lmul4_avl9", 8'd64, 5'd4, 9'd9);
    check_eq("sew64_lmul4_avl9_const", observed(), 32'h4_0000 | (32'd8 << 9) | 32'd1);
    apply("sew64_lmul4_avl5", 8'd64, 5'd4, 9'd5);
    check_eq("sew64_lmul4_avl5_const", observed(), 32'h4_0000 | (32'd5 << 9));

    apply("illegal_sew44", 8'd44, 5'd2, 9'd5);
    check_eq("illegal_sew44_const", observed(), 32'd5);
    apply("illegal_lmul5", 8'd64, 5'd5, 9'd5);
    check_eq("illegal_lmul5_const", observed(), 32'd5);

    apply("vlmax256_avl256", 8'd8, 5'd16, 9'd256);
    check_eq("vlmax256_avl256_const", observed(), 32'h4_0000 | (32'd256 << 9));
    apply("vlmax256_avl500", 8'd8, 5'd16, 9'd500);
    check_eq("vlmax256_avl500_const", observed(), 32'h4_0000 | (32'd256 << 9) | 32'd244);

    apply("vlmax16_avl600_trunc", 8'd128, 5'd16, AVL_W'(600));
    check_eq("vlmax16_avl600_const", observed(), 32'h4_0000 | (32'd16 << 9) | 32'd72);

    apply("avl_zero", 8'd32, 5'd1, 9'd0);
    check_eq("avl_zero_const", observed(), 32'h4_0000);

    // Back-to-back requests with reset pulsed mid-stream
    apply("b2b_a", 8'd16, 5'd2, 9'd3);
    SEW  = 8'd8;
    lmul = 5'd1;
    AVL  = 9'd100;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", observed(), 32'd0);
    @(negedge clk);
    check_eq("inflight_dropped", observed(), 32'd0);
    rst_n = 1'b1;
    apply("after_release", 8'd32, 5'd8, 9'd40);
    apply("b2b_c", 8'd16, 5'd16, 9'd511);

    // Randomized requests, mostly legal encodings
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 9) < 8) ? sew_tab[$urandom_range(0, 4)] : 8'($urandom);
      rl = ($urandom_range(0, 9) < 8) ? lmul_tab[$urandom_range(0, 4)] : 5'($urandom);
      ra = AVL_W'($urandom);
      apply("random", rs, rl, ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
